// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches 16-bit words over req/ack and hands them to decode.
// Optional FETCH_INSTR_COUNT_EN adds a saturating executed-instruction counter port (instr_count).
module fetch_unit #(
  parameter logic [15:0] PC_RESET  = 16'h0000,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [15:0] INSTR_NOP = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] nextPC,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic [15:0] instruction,
  output logic [15:0] currPC,
  output logic [15:0] new_addr,
  output logic        instr_valid,
  output logic        halted,
`ifdef FETCH_INSTR_COUNT_EN
  output logic [15:0] instr_count,
`endif
  output logic        err
);

  localparam int unsigned XLEN  = 16;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   new_addr_q, new_addr_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;

  // State register; output flags are registered alongside the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= PC_RESET;
      new_addr_q <= XLEN'(PC_RESET + XLEN'(2));
      instr_q    <= INSTR_NOP;
      cnt_q      <= '0;
      req_q      <= 1'b1;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      new_addr_q <= new_addr_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: the instruction register reads as NOP outside the EXEC cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    instr_d  = INSTR_NOP;
    req_d    = 1'b0;
    valid_d  = 1'b0;
    halted_d = halted_q;
    err_d    = err_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == TO_LAST) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          req_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (halt) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else if (nextPC[0]) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          pc_d    = nextPC;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
    new_addr_d = XLEN'(pc_d + XLEN'(2));
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [XLEN-1:0] icnt_q, icnt_d;

  // Counts EXEC cycles, saturating at all-ones.
  always_comb begin
    icnt_d = icnt_q;
    if (state_q == S_EXEC && icnt_q != '1) begin
      icnt_d = icnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
    end
  end

  assign instr_count = icnt_q;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign currPC      = pc_q;
  assign new_addr    = new_addr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC-level model predicts each decoded instruction and stage status.
module tb_fetch_unit;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [15:0] NOP     = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] nextPC = '0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [15:0] instruction;
  logic [15:0] currPC;
  logic [15:0] new_addr;
  logic        instr_valid;
  logic        halted;
  logic        err;
`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  fetch_unit #(.PC_RESET(16'h0000), .TIMEOUT(TIMEOUT), .INSTR_NOP(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .nextPC      (nextPC),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instruction (instruction),
    .currPC      (currPC),
    .new_addr    (new_addr),
    .instr_valid (instr_valid),
    .halted      (halted),
`ifdef FETCH_INSTR_COUNT_EN
    .instr_count (instr_count),
`endif
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
    logic [15:0] na;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] model_pc = 16'h0000;
  logic        model_halted = 1'b0;
  logic        model_err = 1'b0;
  int          model_execs = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid instruction must match the oldest predicted fetch.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (instr_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got instruction %04h expected none at %0t", instruction, $time);
        end else begin
          e = sb.pop_front();
          chk16("sb_instruction", instruction, e.ins);
          chk16("sb_currPC", currPC, e.pc);
          chk16("sb_new_addr", new_addr, e.na);
        end
      end else begin
        chk16("nop_when_invalid", instruction, NOP);
      end
    end
  end

  // One fetch/exec step: ack after dly wait cycles, then decode answers with npc/hlt.
  task automatic do_fetch(input int dly, input logic [15:0] rdata, input logic [15:0] npc,
                          input logic hlt);
    exp_t e;
    nextPC = npc;
    halt   = hlt;
    for (int i = 0; i < dly; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
      chk1("req_wait", imem_req, 1'b1);
      chk16("addr_wait", imem_addr, model_pc);
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    chk1("req_ack", imem_req, 1'b1);
    chk16("addr_ack", imem_addr, model_pc);
    e.ins = rdata;
    e.pc  = model_pc;
    e.na  = 16'(model_pc + 16'd2);
    sb.push_back(e);
    @(negedge clk);
    // Stray ack during EXEC must be ignored.
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = 16'($urandom);
    model_execs++;
    @(negedge clk);
    imem_ack = 1'b0;
    chk1("sb_drained", sb.size() == 0, 1'b1);
    if (hlt) model_halted = 1'b1;
    else if (npc[0]) begin
      model_halted = 1'b1;
      model_err    = 1'b1;
    end else model_pc = npc;
    chk1("halted_after", halted, model_halted);
    chk1("err_after", err, model_err);
    chk16("pc_after", currPC, model_pc);
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    imem_ack = 1'b0;
    halt     = 1'b0;
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    model_pc     = 16'h0000;
    model_halted = 1'b0;
    model_err    = 1'b0;
    model_execs  = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] npc;
    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk1("rst_req", imem_req, 1'b1);
    chk16("rst_addr", imem_addr, 16'h0000);
    chk1("rst_valid", instr_valid, 1'b0);
    chk16("rst_instruction", instruction, NOP);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_err", err, 1'b0);

    // Zero-wait fetch, delayed fetch, then halt at 0x0010 (halt beats odd nextPC)
    do_fetch(0, 16'hC005, 16'h0002, 1'b0);
    do_fetch(3, 16'hABCD, 16'h0010, 1'b0);
    do_fetch(0, 16'h1234, 16'h0011, 1'b1);
    for (int i = 0; i < 22; i++) begin
      imem_ack = 1'b1;
      chk1("halt_held", halted, 1'b1);
      chk1("halt_req", imem_req, 1'b0);
      chk1("halt_err", err, 1'b0);
      chk16("halt_currPC", currPC, 16'h0010);
      @(negedge clk);
    end

    // Misaligned nextPC
    reset_dut();
    do_fetch(0, 16'h5555, 16'h0040, 1'b0);
    do_fetch(2, 16'h6666, 16'h0003, 1'b0);
    repeat (3) @(negedge clk);
    chk1("mis_err", err, 1'b1);
    chk1("mis_halted", halted, 1'b1);
    chk1("mis_req", imem_req, 1'b0);
    chk16("mis_currPC", currPC, 16'h0040);

    // Fetch timeout: halted/err appear on cycle TIMEOUT
    reset_dut();
    for (int k = 0; k <= int'(TIMEOUT); k++) begin
      chk1("to_halted", halted, k == int'(TIMEOUT));
      chk1("to_err", err, k == int'(TIMEOUT));
      @(negedge clk);
    end

    // Executed-instruction count and random traffic including a wrap at 0xFFFE
    reset_dut();
    for (int i = 0; i < 5; i++) do_fetch(i % 3, 16'($urandom), 16'(16'h0100 + 16'(2 * i)), 1'b0);
`ifdef FETCH_INSTR_COUNT_EN
    chk16("instr_count_5", instr_count, 16'd5);
`endif
    for (int i = 0; i < 40; i++) begin
      npc = (i == 20) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      do_fetch(int'($urandom_range(0, 4)), 16'($urandom), npc, 1'b0);
      if (i == 20) chk16("wrap_new_addr", new_addr, 16'h0000);
    end
`ifdef FETCH_INSTR_COUNT_EN
    chk16("instr_count_rand", instr_count, 16'(model_execs));
`endif

    // Asynchronous reset in the middle of a FETCH wait
    do_fetch(1, 16'h7777, 16'h1234, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk16("mid_addr", imem_addr, 16'h0000);
    chk16("mid_currPC", currPC, 16'h0000);
    chk16("mid_new_addr", new_addr, 16'h0002);
    chk16("mid_instruction", instruction, NOP);
    chk1("mid_req", imem_req, 1'b1);
    chk1("mid_valid", instr_valid, 1'b0);
    chk1("mid_halted", halted, 1'b0);
    chk1("mid_err", err, 1'b0);
    @(negedge clk);
    reset_dut();
    do_fetch(0, 16'h4321, 16'h0008, 1'b0);

    repeat (2) @(negedge clk);
    chk1("sb_empty_end", sb.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
